// File: rtl/tdc_buf_pkg.sv
// Shared types and constants for the TDC result buffer: entry layout,
// frame FSM states and the interrupt threshold helper.
package tdc_buf_pkg;

  localparam int TDC_DW    = 19;
  localparam int TDC_NUM_W = 3;

  typedef struct packed {
    logic              eof;
    logic [TDC_DW-1:0] data;
  } tdc_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCEPT  = 2'd1,
    DISCARD = 2'd2
  } tdc_state_t;

  // A threshold of zero behaves as one so an enabled irq never fires on an empty buffer.
  function automatic logic [TDC_NUM_W-1:0] thr_floor1(input logic [TDC_NUM_W-1:0] thr);
    return (thr == '0) ? TDC_NUM_W'(1) : thr;
  endfunction

endpackage

// File: rtl/tdc_buf_mem.sv
// Entry storage for the TDC result buffer: synchronous write, combinational
// read so the head entry falls through one cycle after it is written.
module tdc_buf_mem
  import tdc_buf_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  tdc_entry_t                 wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output tdc_entry_t                 rdata
);

  tdc_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tdc_result_buffer.sv
// Frame-atomic FWFT buffer for TDC hit timestamps with frame counting and irq.
// Optional drop statistics counter: define TDC_BUF_STATS_EN to add drop_cnt.
module tdc_result_buffer
  import tdc_buf_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [TDC_DW-1:0]          TDC_Odata,
  input  logic [TDC_NUM_W-1:0]       TDC_Onum,
  input  logic                       TDC_Ovalid,
  input  logic                       rd_pop,
  output logic [TDC_DW-1:0]          rd_data,
  output logic                       rd_eof,
  output logic                       rd_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     frames,
  input  logic                       irq_en,
  input  logic [TDC_NUM_W-1:0]       irq_thr,
  output logic                       irq,
  output logic                       ovf,
  input  logic                       ovf_clr
`ifdef TDC_BUF_STATS_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  tdc_state_t           state, state_nxt;
  logic [TDC_NUM_W-1:0] beat_cnt, beat_cnt_nxt, beat_inc;
  logic [TDC_NUM_W-1:0] frame_len, frame_len_nxt;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 wr_en, wr_eof, drop, pop_en, empty, fits;
  logic [LW-1:0]        free_slots;
  tdc_entry_t           wr_entry, head;

  assign empty      = (level == '0);
  assign pop_en     = rd_pop & ~empty;
  // Space is judged after this cycle's pop, so a pop on the first beat makes room.
  assign free_slots = DEPTH_L - level + LW'(pop_en);
  assign fits       = (free_slots >= LW'(TDC_Onum));
  assign beat_inc   = beat_cnt + TDC_NUM_W'(1);

  always_comb begin
    state_nxt     = state;
    beat_cnt_nxt  = beat_cnt;
    frame_len_nxt = frame_len;
    wr_en         = 1'b0;
    wr_eof        = 1'b0;
    drop          = 1'b0;
    if (TDC_Ovalid) begin
      case (state)
        IDLE: begin
          if (TDC_Onum != '0) begin
            if (fits) begin
              wr_en  = 1'b1;
              wr_eof = (TDC_Onum == TDC_NUM_W'(1));
            end else begin
              drop = 1'b1;
            end
            if (TDC_Onum != TDC_NUM_W'(1)) begin
              state_nxt     = fits ? ACCEPT : DISCARD;
              beat_cnt_nxt  = TDC_NUM_W'(1);
              frame_len_nxt = TDC_Onum;
            end
          end
        end
        ACCEPT, DISCARD: begin
          wr_en = (state == ACCEPT);
          if (beat_inc == frame_len) begin
            wr_eof       = (state == ACCEPT);
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_inc;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      frame_len <= '0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      frame_len <= frame_len_nxt;
    end
  end

  assign wr_entry = {wr_eof, TDC_Odata};

  tdc_buf_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      frames <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      case ({wr_en & wr_eof, pop_en & head.eof})
        2'b10:   frames <= frames + LW'(1);
        2'b01:   frames <= frames - LW'(1);
        default: frames <= frames;
      endcase
    end
  end

  // Status flags: irq tracks the registered frame count, ovf set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
      ovf <= 1'b0;
    end else begin
      irq <= irq_en & (frames >= LW'(thr_floor1(irq_thr)));
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign rd_empty = empty;
  assign rd_data  = empty ? '0 : head.data;
  assign rd_eof   = ~empty & head.eof;

`ifdef TDC_BUF_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       drop_cnt <= '0;
    else if (drop)    drop_cnt <= sat_inc16(drop_cnt);
    else if (ovf_clr) drop_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_tdc_result_buffer.sv
// Bench for tdc_result_buffer: table-driven vectors plus a queue scoreboard model.
module tb_tdc_result_buffer;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic        eof;
    logic [18:0] data;
  } ent_t;

  typedef struct {
    logic        v;
    logic [2:0]  n;
    logic [18:0] d;
    logic        p;
    logic        c;
    int          e_level;
    int          e_frames;
    logic        e_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] odata = '0;
  logic [2:0]  onum = '0;
  logic        ovalid = 1'b0, rd_pop = 1'b0, irq_en = 1'b0, ovf_clr = 1'b0;
  logic [2:0]  irq_thr = '0;
  logic [18:0] rd_data;
  logic        rd_eof, rd_empty, irq, ovf;
  logic [3:0]  level, frames;
`ifdef TDC_BUF_STATS_EN
  logic [15:0] drop_cnt;
`endif

  tdc_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .TDC_Odata(odata), .TDC_Onum(onum), .TDC_Ovalid(ovalid),
    .rd_pop(rd_pop), .rd_data(rd_data), .rd_eof(rd_eof), .rd_empty(rd_empty),
    .level(level), .frames(frames), .irq_en(irq_en), .irq_thr(irq_thr), .irq(irq),
    .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef TDC_BUF_STATS_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #2 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t mq[$];
  int   mst = 0, mcnt = 0, mnum = 0;
  logic m_ovf = 1'b0, m_irq = 1'b0;
  int   m_drops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int m_frames();
    int n = 0;
    foreach (mq[i]) if (mq[i].eof) n++;
    return n;
  endfunction

  // One clock of stimulus; the model advances with it and all outputs are compared after the edge.
  task automatic cycle(input logic v, input logic [2:0] n, input logic [18:0] d,
                       input logic p, input logic c);
    ent_t e;
    int   free;
    int   thr;
    logic drop, irq_nxt;
    ovalid = v; onum = n; odata = d; rd_pop = p; ovf_clr = c;
    thr     = (irq_thr == 3'd0) ? 1 : int'(irq_thr);
    irq_nxt = irq_en && (m_frames() >= thr);
    drop    = 1'b0;
    if (p && mq.size() > 0) begin
      e = mq.pop_front();
      chk("pop_data", 32'(rd_data), 32'(e.data));
      chk("pop_eof", 32'(rd_eof), 32'(e.eof));
    end
    free = DEPTH - mq.size();
    if (v) begin
      case (mst)
        0: if (n != 0) begin
             if (free >= int'(n)) mq.push_back({(n == 3'd1), d});
             else drop = 1'b1;
             if (n > 1) begin
               mst  = (free >= int'(n)) ? 1 : 2;
               mcnt = 1;
               mnum = int'(n);
             end
           end
        default: begin
          mcnt++;
          if (mst == 1) mq.push_back({(mcnt == mnum), d});
          if (mcnt == mnum) mst = 0;
        end
      endcase
    end
    if (c) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    if (drop) begin
      if (m_drops < 65535) m_drops++;
    end else if (c) m_drops = 0;
    @(posedge clk);
    #1;
    m_irq = irq_nxt;
    chk("level", 32'(level), 32'(mq.size()));
    chk("frames", 32'(frames), 32'(m_frames()));
    chk("rd_empty", 32'(rd_empty), 32'(mq.size() == 0));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (mq.size() > 0) begin
      chk("head_data", 32'(rd_data), 32'(mq[0].data));
      chk("head_eof", 32'(rd_eof), 32'(mq[0].eof));
    end else begin
      chk("empty_data", 32'(rd_data), 32'd0);
    end
`ifdef TDC_BUF_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_frames"}, 32'(frames), 32'd0);
    chk({tag, "_empty"}, 32'(rd_empty), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_eof"}, 32'(rd_eof), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    mst = 0; mcnt = 0; mnum = 0;
    m_ovf = 1'b0; m_irq = 1'b0; m_drops = 0;
  endtask

  vec_t tbl[28];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {valid, onum, data, pop, ovf_clr, level, frames, ovf} after the cycle
    tbl[0]  = '{1, 3, 19'h00011, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 19'h00022, 0, 0, 2, 0, 0};
    tbl[2]  = '{1, 0, 19'h00033, 0, 0, 3, 1, 0};
    tbl[3]  = '{0, 0, 19'h0,     1, 0, 2, 1, 0};
    tbl[4]  = '{0, 0, 19'h0,     1, 0, 1, 1, 0};
    tbl[5]  = '{0, 0, 19'h0,     1, 0, 0, 0, 0};
    for (int i = 6; i <= 10; i++) tbl[i] = '{0, 0, 19'h0, 1, 0, 0, 0, 0};
    tbl[11] = '{1, 6, 19'h00100, 0, 0, 1, 0, 0};
    tbl[12] = '{1, 0, 19'h00101, 0, 0, 2, 0, 0};
    tbl[13] = '{1, 0, 19'h00102, 0, 0, 3, 0, 0};
    tbl[14] = '{1, 0, 19'h00103, 0, 0, 4, 0, 0};
    tbl[15] = '{1, 0, 19'h00104, 0, 0, 5, 0, 0};
    tbl[16] = '{1, 0, 19'h00105, 0, 0, 6, 1, 0};
    tbl[17] = '{1, 3, 19'h00200, 0, 0, 6, 1, 1};
    tbl[18] = '{1, 0, 19'h00201, 0, 0, 6, 1, 1};
    tbl[19] = '{1, 0, 19'h00202, 0, 0, 6, 1, 1};
    tbl[20] = '{1, 2, 19'h00300, 1, 0, 6, 1, 1};
    tbl[21] = '{1, 0, 19'h00301, 0, 0, 7, 2, 1};
    tbl[22] = '{1, 2, 19'h00400, 0, 1, 7, 2, 1};
    tbl[23] = '{1, 0, 19'h00401, 0, 1, 7, 2, 0};
    tbl[24] = '{1, 1, 19'h00500, 0, 0, 8, 3, 0};
    tbl[25] = '{1, 1, 19'h00600, 1, 0, 8, 4, 0};
    tbl[26] = '{1, 1, 19'h00700, 0, 0, 8, 4, 1};
    tbl[27] = '{0, 0, 19'h0,     0, 1, 8, 4, 0};

    #1;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      cycle(tbl[i].v, tbl[i].n, tbl[i].d, tbl[i].p, tbl[i].c);
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].e_level));
      chk($sformatf("tbl%0d_frames", i), 32'(frames), 32'(tbl[i].e_frames));
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].e_ovf));
    end

    for (int i = 0; i < 12 && mq.size() > 0; i++) cycle(0, 0, 0, 1, 0);
    chk("drained", 32'(rd_empty), 32'd1);

    // Threshold-2 interrupt: rises a cycle after the frame count reaches 2, falls after a pop.
    irq_en = 1'b1; irq_thr = 3'd2;
    cycle(1, 1, 19'h000A1, 0, 0);
    cycle(1, 1, 19'h000A2, 0, 0);
    chk("irq_pre", 32'(irq), 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("irq_rise", 32'(irq), 32'd1);
    cycle(0, 0, 0, 1, 0);
    chk("irq_hold", 32'(irq), 32'd1);
    cycle(0, 0, 0, 0, 0);
    chk("irq_fall", 32'(irq), 32'd0);
    irq_thr = 3'd0;
    cycle(0, 0, 0, 0, 0);
    chk("irq_thr0", 32'(irq), 32'd1);
    irq_en = 1'b0;
    cycle(0, 0, 0, 0, 0);
    chk("irq_off", 32'(irq), 32'd0);

    // Asynchronous reset during the second beat of a 4-hit frame.
    cycle(1, 4, 19'h00051, 0, 0);
    ovalid = 1'b1; onum = 3'd0; odata = 19'h00052; rd_pop = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    ovalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1, 1, 19'h007AB, 0, 0);
    chk("post_rst_data", 32'(rd_data), 32'h7AB);
    chk("post_rst_eof", 32'(rd_eof), 32'd1);
    chk("post_rst_level", 32'(level), 32'd1);

    for (int blk = 0; blk < 6; blk++) begin
      irq_en  = 1'($urandom_range(0, 1));
      irq_thr = 3'($urandom_range(0, 7));
      for (int i = 0; i < 50; i++)
        cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 19'($urandom),
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
    end
    irq_en = 1'b0;

    for (int i = 0; i < 12 && (mq.size() > 0 || mst != 0); i++) cycle(0, 0, 0, 1, 0);
    chk("drained2", 32'(rd_empty), 32'd1);

`ifdef TDC_BUF_STATS_EN
    cycle(0, 0, 0, 0, 1);
    cycle(1, 7, 19'h00800, 0, 0);
    for (int i = 1; i < 7; i++) cycle(1, 0, 19'(19'h00800 + i), 0, 0);
    for (int f = 0; f < 3; f++) begin
      cycle(1, 2, 19'h00900, 0, 0);
      cycle(1, 0, 19'h00901, 0, 0);
    end
    chk("stats_cnt3", 32'(drop_cnt), 32'd3);
    chk("stats_ovf1", 32'(ovf), 32'd1);
    cycle(0, 0, 0, 0, 1);
    chk("stats_clr_cnt", 32'(drop_cnt), 32'd0);
    chk("stats_clr_ovf", 32'(ovf), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_result_buffer.md
TDC_RESULT_BUFFER -- requirements
Module: tdc_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; a power of two, minimum 8.
REQ-002 SHALL have port clk, input, 1 bit: 250 MHz logic clock, same as the TDC logic clock.
REQ-003 SHALL have port rst_n, input, 1 bit: active-low reset, asynchronous assert; one clock domain, clk only.
REQ-004 SHALL have port TDC_Odata, input, 19 bits: one hit timestamp per valid beat.
REQ-005 SHALL have port TDC_Onum, input, 3 bits: hit count of the frame, sampled on the first beat of the frame.
REQ-006 SHALL have port TDC_Ovalid, input, 1 bit: beat valid; no ready back-pressure, every beat is consumed.
REQ-007 SHALL have port rd_pop, input, 1 bit: single-cycle pop request from the SPI register block.
REQ-008 SHALL have port rd_data, output, 19 bits: head entry timestamp.
REQ-009 SHALL have port rd_eof, output, 1 bit: head entry is the last hit of its frame.
REQ-010 SHALL have port rd_empty, output, 1 bit: buffer empty.
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-012 SHALL have port frames, output, $clog2(DEPTH)+1 bits: number of complete stored frames.
REQ-013 SHALL have ports irq_en (input, 1 bit) and irq_thr (input, 3 bits): interrupt enable and frame threshold.
REQ-014 SHALL have port irq, output, 1 bit: level interrupt, routed to INT0/INT1.
REQ-015 SHALL have ports ovf (output, 1 bit) and ovf_clr (input, 1 bit): sticky frame-drop flag and its clear.

Function
REQ-016 SHALL implement a frame FSM with states IDLE, ACCEPT and DISCARD, plus a 3-bit beat counter.
REQ-017 IDLE, beat with TDC_Onum=0: SHALL discard the beat and stay in IDLE.
REQ-018 IDLE, beat with Onum=N>0 and free slots (DEPTH-level) >= N: SHALL write the beat and go to ACCEPT if N>1; for N=1, SHALL write with eof=1 and stay in IDLE.
REQ-019 IDLE, beat with Onum=N>0 and free slots < N: SHALL drop the whole frame, set ovf, and go to DISCARD if N>1.
REQ-020 ACCEPT/DISCARD: SHALL count beats; the Nth beat SHALL end the frame and return to IDLE. In ACCEPT the Nth beat is written with eof=1; in DISCARD all beats are dropped.
REQ-021 Free-slot check SHALL use level after the same-cycle pop, so a pop on the first-beat cycle frees a slot.
REQ-022 Once admitted, a frame SHALL never be truncated.
REQ-023 Buffer SHALL be first-word-fall-through: an entry written in cycle N appears on rd_data/rd_eof, with rd_empty low, in cycle N+1.
REQ-024 rd_pop with rd_empty=1 SHALL be ignored; level and pointers stay unchanged.
REQ-025 Simultaneous write and pop SHALL leave level unchanged. Write of an eof entry with pop of an eof entry SHALL leave frames unchanged.
REQ-026 Pointers SHALL wrap modulo DEPTH; full is level==DEPTH.
REQ-027 frames SHALL increment on an eof write and decrement on an eof pop.
REQ-028 irq SHALL be registered: irq = irq_en & (frames >= max(irq_thr,1)), valid one cycle after frames changes.
REQ-029 ovf_clr and a new drop in the same cycle: the set SHALL win.

Reset
REQ-030 rst_n low SHALL asynchronously force: FSM to IDLE; beat counter, pointers, level and frames to 0; rd_empty=1; rd_data=0; rd_eof=0; irq=0; ovf=0.
REQ-031 Reset mid-frame SHALL discard partial state; after release the next beat is treated as a first beat.
REQ-032 Reset de-assertion SHALL arrive already synchronised to clk.

Configuration
REQ-033 With TDC_BUF_STATS_EN defined: SHALL add output drop_cnt, 16 bits, incremented once per dropped frame, saturating at 0xFFFF and cleared by ovf_clr (an increment wins over the clear).
REQ-034 Without TDC_BUF_STATS_EN: the drop_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-035 Package tdc_buf_pkg SHALL hold: TDC_DW=19, TDC_NUM_W=3, a packed entry typedef {eof, data[18:0]}, and an FSM state enum.
REQ-036 Storage SHALL be sub-module tdc_buf_mem: DEPTH x 20-bit, one write port and one read port, synchronous write.

Verification
REQ-037 Empty buffer, frame Onum=3, data 0x00011/0x00022/0x00033 -> level=3, frames=1; popped order 0x11, 0x22, 0x33 with eof on the 3rd only.
REQ-038 level=6 (DEPTH=8), frame Onum=3 -> whole frame dropped, ovf=1, level stays 6. A following Onum=2 frame with a pop on its first beat -> accepted, level=7.
REQ-039 irq_en=1, irq_thr=2, two 1-hit frames written -> irq rises one cycle after the 2nd eof write; one pop -> irq falls.
REQ-040 rd_pop on an empty buffer for 5 cycles -> level=0, rd_empty=1, no pointer movement.
REQ-041 rst_n pulsed low during the 2nd beat of an Onum=4 frame -> all outputs at reset values; next Onum=1 beat accepted as a new frame.
REQ-042 With TDC_BUF_STATS_EN: 3 dropped frames -> drop_cnt=3; ovf_clr -> drop_cnt=0, ovf=0.
